// File: rtl/reg_file_sb.sv
// Scoreboarded register file: combinational write-first reads, per-register
// busy bitmap set on issue / cleared on writeback, registered debug mirror.
module reg_file_sb #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned DBG_REG    = 10
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data_o,
  output logic [READ_PORTS-1:0]            rd_busy_o,
  input  logic                             wr_en_i,
  input  logic [ADDR_WIDTH-1:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0]            wr_data_i,
  input  logic                             iss_en_i,
  input  logic [ADDR_WIDTH-1:0]            iss_addr_i,
  output logic [DATA_WIDTH-1:0]            dbg_o,
  output logic [ADDR_WIDTH:0]              busy_cnt_o
);

  localparam int unsigned NREG  = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] DBG_IDX = ADDR_WIDTH'(DBG_REG);

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0]       busy_q, busy_d;
  logic [CNT_W-1:0]      busy_cnt_q, busy_cnt_d;
  logic [DATA_WIDTH-1:0] dbg_q;
  logic                  wr_vld, iss_vld, cnt_inc, cnt_dec;

  always_comb begin
    wr_vld  = wr_en_i && (wr_addr_i != '0);
    iss_vld = iss_en_i && (iss_addr_i != '0);
    busy_d  = busy_q;
    if (wr_vld)  busy_d[wr_addr_i]  = 1'b0;
    if (iss_vld) busy_d[iss_addr_i] = 1'b1;
    // Incremental popcount: a same-address issue+writeback keeps the bit, so no decrement.
    cnt_inc    = iss_vld && !busy_q[iss_addr_i];
    cnt_dec    = wr_vld && busy_q[wr_addr_i] && !(iss_vld && (iss_addr_i == wr_addr_i));
    busy_cnt_d = busy_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    logic                  byp;
    logic                  iss_hit;
    ra        = '0;
    byp       = 1'b0;
    iss_hit   = 1'b0;
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      ra      = rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      byp     = wr_vld && (ra == wr_addr_i);
      iss_hit = iss_vld && (ra == iss_addr_i);
      if (ra == '0)
        rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if (byp)
        rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = wr_data_i;
      else
        rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
      rd_busy_o[p] = busy_q[ra] && !(byp && !iss_hit);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
      dbg_q      <= '0;
    end else begin
      if (wr_vld) regs_q[wr_addr_i] <= wr_data_i;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      dbg_q      <= regs_q[DBG_IDX];
    end
  end

  assign dbg_o      = dbg_q;
  assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: a behavioural model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_reg_file_sb;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RP = 2;
  localparam int NR = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [RP*AW-1:0] rd_addr_i;
  logic [RP*DW-1:0] rd_data_o;
  logic [RP-1:0]    rd_busy_o;
  logic             wr_en_i;
  logic [AW-1:0]    wr_addr_i;
  logic [DW-1:0]    wr_data_i;
  logic             iss_en_i;
  logic [AW-1:0]    iss_addr_i;
  logic [DW-1:0]    dbg_o;
  logic [AW:0]      busy_cnt_o;

  always #5 clk_i = ~clk_i;

  reg_file_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(RP), .DBG_REG(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_busy_o(rd_busy_o), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .iss_en_i(iss_en_i), .iss_addr_i(iss_addr_i),
    .dbg_o(dbg_o), .busy_cnt_o(busy_cnt_o)
  );

  typedef struct {
    bit          chk;
    string       name;
    logic [DW-1:0] rd [RP];
    logic [RP-1:0] busy;
    logic [AW:0]   cnt;
    logic [DW-1:0] dbg;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  // Reference state: register contents, busy flags and last-cycle debug mirror.
  logic [DW-1:0] m_mem [NR];
  bit            m_busy [NR];
  logic [DW-1:0] m_dbg;

  initial begin
    for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    m_dbg = '0;
  end

  task automatic cmp(input string name, input string field, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", name, field, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit wen, input int waddr, input logic [DW-1:0] wdata,
                      input bit ien, input int iaddr, input int ra0, input int ra1,
                      input string name, input bit chk = 1);
    exp_t e;
    int   ra [RP];
    int   n;
    bit   wh, ih;
    rst_i      = rst;
    wr_en_i    = wen;
    wr_addr_i  = waddr[AW-1:0];
    wr_data_i  = wdata;
    iss_en_i   = ien;
    iss_addr_i = iaddr[AW-1:0];
    rd_addr_i  = {ra1[AW-1:0], ra0[AW-1:0]};
    ra[0] = ra0;
    ra[1] = ra1;
    e.chk  = chk;
    e.name = name;
    e.busy = '0;
    for (int p = 0; p < RP; p++) begin
      wh = wen && waddr != 0 && waddr == ra[p];
      ih = ien && iaddr != 0 && iaddr == ra[p];
      e.rd[p]   = (ra[p] == 0) ? '0 : (wh ? wdata : m_mem[ra[p]]);
      e.busy[p] = m_busy[ra[p]] && !(wh && !ih);
    end
    n = 0;
    for (int i = 0; i < NR; i++) if (m_busy[i]) n++;
    e.cnt = n[AW:0];
    e.dbg = m_dbg;
    sbq.push_back(e);
    @(posedge clk_i);
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
      m_dbg = '0;
    end else begin
      m_dbg = m_mem[10];
      if (wen && waddr != 0) begin m_mem[waddr] = wdata; m_busy[waddr] = 0; end
      if (ien && iaddr != 0) m_busy[iaddr] = 1;
    end
    #1;
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.chk) begin
        for (int p = 0; p < RP; p++) begin
          cmp(e.name, $sformatf("rd_data%0d", p), 64'(rd_data_o[p*DW +: DW]), 64'(e.rd[p]));
          cmp(e.name, $sformatf("rd_busy%0d", p), 64'(rd_busy_o[p]), 64'(e.busy[p]));
        end
        cmp(e.name, "busy_cnt", 64'(busy_cnt_o), 64'(e.cnt));
        cmp(e.name, "dbg", 64'(dbg_o), 64'(e.dbg));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wa, ia, r0, r1, sel;
    rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    iss_en_i = 1'b0; iss_addr_i = '0; rd_addr_i = '0;
    @(posedge clk_i); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, "rst_first", 0);
    step(1, 1, 6, 32'h1111, 1, 6, 6, 0, "rst_hold");

    for (int a = 0; a < NR; a++) step(0, 0, 0, 0, 0, 0, a, NR - 1 - a, "rst_read");

    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, "byp_x5");
    step(0, 0, 0, 0, 0, 0, 5, 5, "hold_x5");
    step(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 5, "wr_x0");
    step(0, 0, 0, 0, 1, 0, 0, 0, "x0_zero");

    step(0, 0, 0, 0, 1, 7, 7, 1, "iss_x7");
    step(0, 1, 7, 32'h12, 0, 0, 7, 0, "wb_x7");
    step(0, 0, 0, 0, 0, 0, 7, 7, "x7_clear");

    step(0, 1, 3, 32'hAA, 1, 3, 3, 0, "iss_wb_x3");
    step(0, 0, 0, 0, 1, 3, 3, 3, "reiss_x3");
    step(0, 0, 0, 0, 0, 0, 3, 0, "x3_busy");
    step(0, 1, 3, 32'hBB, 1, 8, 3, 8, "set_clr_diff");
    step(0, 1, 8, 32'hCC, 0, 0, 8, 3, "x8_clear");

    step(0, 1, 10, 32'h55, 0, 0, 10, 0, "wr_x10");
    step(0, 0, 0, 0, 0, 0, 10, 0, "dbg_before");
    step(0, 0, 0, 0, 0, 0, 10, 0, "dbg_after");

    step(0, 0, 0, 0, 1, 4, 4, 0, "iss_x4");
    step(0, 0, 0, 0, 1, 9, 4, 9, "iss_x9");
    step(0, 0, 0, 0, 1, 12, 9, 12, "iss_x12");
    step(1, 1, 4, 32'h77, 1, 5, 4, 12, "rst_vs_wr");
    step(0, 0, 0, 0, 0, 0, 4, 12, "post_rst");
    step(0, 0, 0, 0, 0, 0, 9, 10, "post_rst2");

    for (int c = 0; c < 800; c++) begin
      wa  = $urandom_range(0, NR - 1);
      ia  = $urandom_range(0, NR - 1);
      sel = $urandom_range(0, 2);
      r0  = (sel == 0) ? wa : (sel == 1) ? ia : $urandom_range(0, NR - 1);
      r1  = ($urandom_range(0, 1) == 0) ? wa : $urandom_range(0, NR - 1);
      step($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1, wa, $urandom,
           $urandom_range(0, 2) != 0, ia, r0, r1, "random");
    end

    rst_i = 1'b0; wr_en_i = 1'b0; iss_en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
